desc_rr_sched: RTL
==================

// Module: desc_rr_sched
// PURPOSE
// Round-robin queue scheduler sitting directly downstream of the per-queue desc_cnt instances.
// Consumes their desc_rdy vector plus per-queue enable/pending flags and issues one queue grant at a time.
// Each grant uses a valid/ready handshake to the packet engine.
// Each accepted grant pulses desc_cnt_dec for that queue, consuming exactly one descriptor credit.
// PARAMETERS
// NUM_Q     8   number of queues scheduled (>=2)
// QID_W     $clog2(NUM_Q)   width of grant_qid
// CNT_W     32  width of total grant counter
// PORTS
// user_clk      in   1      single clock; all logic on posedge
// user_reset_n  in   1      synchronous, active-low reset
// q_rdy         in   NUM_Q  desc_rdy from each desc_cnt instance (registered there)
// q_en          in   NUM_Q  software queue enable
// q_pend        in   NUM_Q  queue has data waiting to send
// q_clr         in   NUM_Q  queue clear (same pulse driven to desc_cnt_clr)
// desc_dec      out  NUM_Q  one-hot decrement pulse to desc_cnt_dec
// grant_vld     out  1      grant offered
// grant_qid     out  QID_W  granted queue; stable while grant_vld & !grant_rdy
// grant_rdy     in   1      packet engine accepts grant
// grant_cnt     out  CNT_W  total accepted grants, wraps modulo 2^CNT_W
// BEHAVIOUR
// Reset:
// - state=S_IDLE, grant_vld=0, grant_qid=0, rr_ptr=0, grant_cnt=0.
// - desc_dec=0 is combinational from the handshake.
// Eligibility: elig = q_rdy & q_en & q_pend & ~q_clr.
// Arbitration: first set bit of elig at or after rr_ptr, wrapping around NUM_Q-1 -> 0.
// FSM (desc_sched_pkg::sched_state_e):
// - S_IDLE: if |elig, register winner into grant_qid, grant_vld<=1, rr_ptr<=winner+1 (mod NUM_Q) -> S_OFFER.
//   Latency is 1 cycle from elig to grant_vld.
// - S_OFFER, handshake (grant_vld & grant_rdy):
//   - desc_dec[grant_qid]=1 in that same cycle (combinational, exactly one cycle).
//   - grant_cnt++.
//   - Re-arbitrate the same cycle over elig with bit grant_qid masked.
//   - If a winner exists: load it, keep grant_vld=1, stay in S_OFFER (back-to-back; full rate with >=2 eligible queues).
//   - Otherwise: grant_vld<=0 -> S_IDLE.
// - S_OFFER, no handshake: hold grant_qid/grant_vld; do not re-arbitrate.
// Masking rationale: desc_rdy lags a decrement by one cycle, so the just-granted queue is never re-granted
// in the cycle after its dec. A lone eligible queue therefore sees at most one grant every 2 cycles.
// Abort: q_clr[grant_qid] in S_OFFER with no handshake:
// - grant_vld<=0, no desc_dec, -> S_IDLE.
// - This is the only permitted valid withdrawal.
// Simultaneous q_clr[grant_qid] and grant_rdy: clear wins; no dec, no count, grant is dropped.
//   The packet engine must qualify grant_rdy with grant_vld & !q_clr.
// q_rdy/q_en drop while a grant is offered (except via q_clr): grant is held. desc_cnt saturates at 0, so a late dec is harmless.
// Reset asserted mid-offer: grant_vld=0 next cycle; no desc_dec during reset.
// desc_dec is never multi-hot; never asserted while user_reset_n=0.
// STRUCTURE
// desc_sched_pkg:
// - sched_state_e {S_IDLE, S_OFFER}
// - function rr_next(ptr, NUM_Q)
// - localparam helper for QID_W
// Sub-module rr_arbiter #(NUM_Q):
// - combinational; req, ptr -> gnt_vld, gnt_idx
// - double-width masked priority encode
// - instantiated once; the mask is applied by the caller
// TESTING
// 1. Reset, then elig=8'h01, grant_rdy=1: grant_vld at cycle 1, desc_dec=8'h01, then alternating idle cycles (masking). grant_cnt increments by 1 per 2 cycles.
// 2. elig=8'hFF, grant_rdy=1 for 16 cycles: qids 0..7,0..7 back-to-back; desc_dec one-hot each cycle; grant_cnt=16.
// 3. elig=8'h24, grant_rdy=0 for 5 cycles then 1: grant_qid=2 held stable 5 cycles; on accept desc_dec=8'h04; next grant qid=5.
// 4. Offering qid=3, pulse q_clr=8'h08 with grant_rdy=0: grant_vld falls next cycle, desc_dec stays 0, grant_cnt unchanged.
// 5. Same as 4 with grant_rdy=1 in the clear cycle: no dec, no count; with other queues eligible, next grant issues from S_IDLE.
// 6. Assert user_reset_n=0 mid-offer for 1 cycle: all outputs return to reset values; rr_ptr=0; first grant after reset goes to lowest eligible qid.

Source files
------------

// File: rtl/desc_sched_pkg.sv
// Shared types and helpers for the descriptor round-robin scheduler.
package desc_sched_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } sched_state_e;

    localparam int unsigned DEF_NUM_Q = 8;
    localparam int unsigned DEF_QID_W = $clog2(DEF_NUM_Q);

    // Round-robin pointer advance, wrapping num_q-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_q);
        return (ptr + 32'd1 >= num_q) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_Q = 8,
    parameter int unsigned QID_W = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [QID_W-1:0] gnt_idx
);

    localparam int unsigned DW = 2 * NUM_Q;

    logic [DW-1:0] dbl_req;
    logic [DW-1:0] dbl_mask;
    logic [DW-1:0] dbl_hit;

    // Upper copy of req covers the wrap; lower copy is masked below ptr.
    always_comb begin
        dbl_req  = {req, req};
        dbl_mask = ~((DW'(1) << ptr) - DW'(1));
        dbl_hit  = dbl_req & dbl_mask;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (dbl_hit[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = (i >= NUM_Q) ? QID_W'(i - NUM_Q) : QID_W'(i);
            end
        end
    end

endmodule

// File: rtl/desc_rr_sched.sv
// Round-robin queue scheduler: offers one queue grant at a time to the packet engine
// and pulses the matching desc_cnt decrement on each accepted grant.
module desc_rr_sched
    import desc_sched_pkg::*;
#(
    parameter int unsigned NUM_Q = DEF_NUM_Q,
    parameter int unsigned QID_W = $clog2(NUM_Q),
    parameter int unsigned CNT_W = 32
) (
    input  logic             user_clk,
    input  logic             user_reset_n,
    input  logic [NUM_Q-1:0] q_rdy,
    input  logic [NUM_Q-1:0] q_en,
    input  logic [NUM_Q-1:0] q_pend,
    input  logic [NUM_Q-1:0] q_clr,
    output logic [NUM_Q-1:0] desc_dec,
    output logic             grant_vld,
    output logic [QID_W-1:0] grant_qid,
    input  logic             grant_rdy,
    output logic [CNT_W-1:0] grant_cnt
);

    sched_state_e     state;
    logic [QID_W-1:0] rr_ptr;
    logic [NUM_Q-1:0] elig;
    logic [NUM_Q-1:0] qid_oh;
    logic [NUM_Q-1:0] arb_req;
    logic             arb_vld;
    logic [QID_W-1:0] arb_idx;
    logic             offer;
    logic             clr_hit;
    logic             hs;

    // The just-granted queue is masked because its desc_rdy lags the decrement by a cycle.
    always_comb begin
        qid_oh   = NUM_Q'(1) << grant_qid;
        elig     = q_rdy & q_en & q_pend & ~q_clr;
        offer    = (state == S_OFFER);
        clr_hit  = |(q_clr & qid_oh);
        hs       = offer & grant_vld & grant_rdy & ~clr_hit;
        arb_req  = offer ? (elig & ~qid_oh) : elig;
        desc_dec = (hs & user_reset_n) ? qid_oh : '0;
    end

    rr_arbiter #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // Scheduler FSM; a clear on the offered queue is the only withdrawal path.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            state     <= S_IDLE;
            grant_vld <= 1'b0;
            grant_qid <= '0;
            rr_ptr    <= '0;
            grant_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_vld) begin
                        grant_qid <= arb_idx;
                        grant_vld <= 1'b1;
                        rr_ptr    <= QID_W'(rr_next(32'(arb_idx), NUM_Q));
                        state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (clr_hit) begin
                        grant_vld <= 1'b0;
                        state     <= S_IDLE;
                    end else if (hs) begin
                        grant_cnt <= grant_cnt + CNT_W'(1);
                        if (arb_vld) begin
                            grant_qid <= arb_idx;
                            rr_ptr    <= QID_W'(rr_next(32'(arb_idx), NUM_Q));
                        end else begin
                            grant_vld <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    grant_vld <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
